// File: rtl/lfsr_gal_param.sv
// -----------------------------------------------------------------------------
// lfsr_gal_param
//
// Parametrised Galois (right-shifting) LFSR pseudo-random generator with a
// serial-to-word assembler on a valid/ready output stream.
//
// Each enabled step emits state[0] and advances the register by
//   next = (state >> 1) ^ (state[0] ? TAPS : 0).
// Emitted bits are packed LSB-first into OUT_W-bit words. While a finished
// word waits for the consumer, the generator freezes so no bits are lost.
// A runtime seed load is provided. A zero seed would lock the register in
// the all-zero state, so it is replaced by SEED and flagged on `lockup`.
//
// Parameters:
//   WIDTH  - LFSR state width (4..64)
//   TAPS   - Galois feedback mask, WIDTH bits
//   SEED   - reset / lockup-recovery state, WIDTH bits, non-zero
//   OUT_W  - bits per assembled output word (1..WIDTH)
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous reset, active-high, highest priority
//   en         in   request one LFSR step this cycle
//   load       in   load seed_in (or SEED if zero); overrides en
//   seed_in    in   runtime seed, WIDTH bits
//   lfsr_out   out  serial bit, combinational tap of state[0]
//   state_out  out  current LFSR state
//   word_out   out  assembled word, bit k = k-th emitted bit
//   word_valid out  word_out holds a complete word
//   word_ready in   consumer accepts word_out
//   lockup     out  one-cycle pulse after a zero seed was rejected
// -----------------------------------------------------------------------------
module lfsr_gal_param #(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] TAPS  = 16'hB400,
    parameter logic [WIDTH-1:0] SEED  = 16'h0001,
    parameter int               OUT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] seed_in,
    output logic             lfsr_out,
    output logic [WIDTH-1:0] state_out,
    output logic [OUT_W-1:0] word_out,
    output logic             word_valid,
    input  logic             word_ready,
    output logic             lockup
);

    // A 1-bit word still needs a 1-bit counter to keep the logic well formed.
    localparam int               CNT_W    = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OUT_W - 1);

    logic [WIDTH-1:0] state;
    logic [WIDTH-1:0] state_next;
    logic [CNT_W-1:0] cnt;
    logic [OUT_W-1:0] partial;
    logic [OUT_W-1:0] word_next;
    logic             adv;
    logic             word_done;

    // -------------------------------------------------------------------------
    // Combinational step, advance qualification and word assembly
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every always_comb output gets a default before any condition,
        // so no path can leave it unassigned and infer a latch.
        state_next = (state >> 1) ^ (state[0] ? TAPS : '0);

        // A pending word that the consumer has not taken blocks stepping.
        adv       = en && !load && !(word_valid && !word_ready);
        word_done = adv && (cnt == CNT_LAST);

        // Drop the bit about to be emitted into its slot of the partial word.
        word_next = partial;
        for (int k = 0; k < OUT_W; k++) begin
            if (cnt == CNT_W'(k)) begin
                word_next[k] = state[0];
            end
        end
    end

    // -------------------------------------------------------------------------
    // State, counter and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values, independent of statement order.
        if (rst) begin
            state      <= SEED;
            cnt        <= '0;
            partial    <= '0;
            word_out   <= '0;
            word_valid <= 1'b0;
            lockup     <= 1'b0;
        end else begin
            lockup <= 1'b0;

            if (load) begin
                // A zero seed would stick at zero forever; recover with SEED.
                state      <= (seed_in == '0) ? SEED : seed_in;
                lockup     <= (seed_in == '0);
                cnt        <= '0;
                partial    <= '0;
                word_valid <= 1'b0;
            end else begin
                if (adv) begin
                    state <= state_next;
                    if (word_done) begin
                        cnt        <= '0;
                        partial    <= '0;
                        word_out   <= word_next;
                        word_valid <= 1'b1;
                    end else begin
                        cnt     <= cnt + 1'b1;
                        partial <= word_next;
                    end
                end

                // Transfer completes; keep valid high only if a new word
                // landed in the same cycle.
                if (word_valid && word_ready && !word_done) begin
                    word_valid <= 1'b0;
                end
            end
        end
    end

    assign lfsr_out  = state[0];
    assign state_out = state;

endmodule

// File: tb/tb_lfsr_gal_param.sv
// -----------------------------------------------------------------------------
// tb_lfsr_gal_param
//
// Directed bench for lfsr_gal_param. Stimulus pushes each expected word into
// a queue; a monitor on the falling edge pops and compares whenever a word is
// transferred (word_valid && word_ready). State, lockup and handshake values
// are compared directly against hand-computed constants. A second instance
// (WIDTH=8, TAPS=8'hB8) runs alongside for the 8-bit period check.
// -----------------------------------------------------------------------------
module tb_lfsr_gal_param;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        load;
    logic [15:0] seed_in;
    logic        lfsr_out;
    logic [15:0] state_out;
    logic [7:0]  word_out;
    logic        word_valid;
    logic        word_ready;
    logic        lockup;

    logic        lfsr_out_8;
    logic [7:0]  state_out_8;
    logic [2:0]  word_out_8;
    logic        word_valid_8;
    logic        lockup_8;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];
    logic       sb_on = 1'b1;

    always #5 clk = ~clk;

    lfsr_gal_param #(
        .WIDTH (16),
        .TAPS  (16'hB400),
        .SEED  (16'h0001),
        .OUT_W (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .load       (load),
        .seed_in    (seed_in),
        .lfsr_out   (lfsr_out),
        .state_out  (state_out),
        .word_out   (word_out),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .lockup     (lockup)
    );

    lfsr_gal_param #(
        .WIDTH (8),
        .TAPS  (8'hB8),
        .SEED  (8'h01),
        .OUT_W (3)
    ) dut_8 (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .load       (1'b0),
        .seed_in    (8'h00),
        .lfsr_out   (lfsr_out_8),
        .state_out  (state_out_8),
        .word_out   (word_out_8),
        .word_valid (word_valid_8),
        .word_ready (1'b1),
        .lockup     (lockup_8)
    );

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: a word is transferred on the next rising edge.
    always @(negedge clk) begin
        if (sb_on && word_valid && word_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL word_unexpected: got 0x%0h, expected no word",
                         word_out);
            end else begin
                check("word_out", 64'(word_out), 64'(exp_q.pop_front()));
            end
        end
    end

    logic [15:0] t1_states [8] = '{16'hB400, 16'h5A00, 16'h2D00, 16'h1680,
                                   16'h0B40, 16'h05A0, 16'h02D0, 16'h0168};

    initial begin
        int  n16;
        int  n8;
        bit  zero16;
        bit  zero8;

        rst        = 1'b1;
        en         = 1'b0;
        load       = 1'b0;
        seed_in    = 16'h0000;
        word_ready = 1'b1;
        tick();
        tick();

        // Reset state
        check("rst_state",  64'(state_out),  64'h0001);
        check("rst_valid",  64'(word_valid), 64'h0);
        check("rst_word",   64'(word_out),   64'h00);
        check("rst_lockup", 64'(lockup),     64'h0);
        check("rst_serial", 64'(lfsr_out),   64'h1);

        // 1. First 8 steps from reset, first word 0x01
        rst = 1'b0;
        en  = 1'b1;
        exp_q.push_back(8'h01);
        for (int i = 0; i < 8; i++) begin
            tick();
            check("t1_state", 64'(state_out), 64'(t1_states[i]));
        end
        check("t1_valid", 64'(word_valid), 64'h1);
        check("t1_word",  64'(word_out),   64'h01);

        // 2. Next 8 steps: state 0x7C41, word 0x68
        exp_q.push_back(8'h68);
        for (int i = 0; i < 8; i++) tick();
        check("t2_state", 64'(state_out),  64'h7C41);
        check("t2_valid", 64'(word_valid), 64'h1);
        check("t2_word",  64'(word_out),   64'h68);

        // 3. Back-pressure freezes state and word
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.push_back(8'h01);
        for (int i = 0; i < 8; i++) tick();
        word_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t3_hold_state", 64'(state_out),  64'h0168);
            check("t3_hold_word",  64'(word_out),   64'h01);
            check("t3_hold_valid", 64'(word_valid), 64'h1);
        end
        exp_q.push_back(8'h68);
        word_ready = 1'b1;
        tick();
        check("t3_resume", 64'(state_out), 64'h00B4);
        for (int i = 0; i < 7; i++) tick();
        check("t3_state", 64'(state_out),  64'h7C41);
        check("t3_valid", 64'(word_valid), 64'h1);
        check("t3_word",  64'(word_out),   64'h68);

        // 4. Zero-seed rejection, then a real seed restarting the word
        load    = 1'b1;
        seed_in = 16'h0000;
        tick();
        check("t4_zero_state",  64'(state_out),  64'h0001);
        check("t4_zero_lockup", 64'(lockup),     64'h1);
        check("t4_zero_valid",  64'(word_valid), 64'h0);
        load = 1'b0;
        tick();
        check("t4_lockup_clear", 64'(lockup),    64'h0);
        check("t4_step",         64'(state_out), 64'hB400);
        tick();
        tick();
        load    = 1'b1;
        seed_in = 16'hACE1;
        tick();
        check("t4_seed_state",  64'(state_out),  64'hACE1);
        check("t4_seed_lockup", 64'(lockup),     64'h0);
        check("t4_seed_valid",  64'(word_valid), 64'h0);
        load = 1'b0;
        exp_q.push_back(8'hE1);
        for (int i = 0; i < 7; i++) tick();
        check("t4_no_early_word", 64'(word_valid), 64'h0);
        tick();
        check("t4_state", 64'(state_out),  64'hC2C4);
        check("t4_valid", 64'(word_valid), 64'h1);
        check("t4_word",  64'(word_out),   64'hE1);

        // 5. Reset mid-word with en held high
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("t5_state", 64'(state_out),  64'h0001);
        check("t5_valid", 64'(word_valid), 64'h0);
        check("t5_word",  64'(word_out),   64'h00);
        rst = 1'b0;
        exp_q.push_back(8'h01);
        for (int i = 0; i < 8; i++) tick();
        check("t5_state_after", 64'(state_out),  64'h0168);
        check("t5_valid_after", 64'(word_valid), 64'h1);
        check("t5_word_after",  64'(word_out),   64'h01);

        // Let the monitor take the last word, then stop scoreboarding.
        @(negedge clk);
        #1;
        sb_on = 1'b0;
        check("queue_drained", 64'(exp_q.size()), 64'h0);

        // 6. Full period for both widths
        rst = 1'b1;
        tick();
        rst    = 1'b0;
        n16    = 0;
        n8     = 0;
        zero16 = 1'b0;
        zero8  = 1'b0;
        for (int i = 1; i <= 65600; i++) begin
            tick();
            if (state_out == 16'h0000) zero16 = 1'b1;
            if (state_out_8 == 8'h00) zero8 = 1'b1;
            if (n8 == 0 && state_out_8 == 8'h01) n8 = i;
            if (state_out == 16'h0001) begin
                n16 = i;
                break;
            end
        end
        check("period_16", 64'(n16),    64'd65535);
        check("zero_16",   64'(zero16), 64'h0);
        check("period_8",  64'(n8),     64'd255);
        check("zero_8",    64'(zero8),  64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
